// File: rtl/mips_pkg.sv
// mips_pkg -- shared definitions for the MIPS datapath slice.
//   fetch_state_e : fetch-stage FSM states (FETCH / WAIT / HOLD)
//   INSTR_W       : instruction width in bits
//   WORD_BYTES    : bytes per instruction word (PC increment)
//   NOP_INSTR     : value held in the instruction register after reset
package mips_pkg;

  localparam int INSTR_W    = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// pc_reg -- program counter register for the fetch stage.
//   clk, rst_n : clock, synchronous active-low reset (loads RESET_PC)
//   load       : take load_pc (low two bits forced to zero); wins over inc
//   load_pc    : redirect target
//   inc        : advance by one word, wrapping modulo 2^ADDR_W
//   pc         : current program counter, always word aligned
module pc_reg
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc & ALIGN_MASK;
    end else if (inc) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch -- MIPS instruction fetch stage.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FETCH | request presented at pc, waiting for imem_gnt
//   WAIT  | request granted, waiting for imem_rvalid (discard => drop it)
//   HOLD  | instruction held on if_* until decode takes it
//
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   imem_req/imem_addr         : fetch request (decoded from state and pc)
//   imem_gnt                   : memory accepted the request
//   imem_rvalid/imem_rdata     : fetch response
//   redirect_valid/redirect_pc : branch/jump redirect, highest priority
//   if_valid/if_instr/if_pc    : registered instruction to decode
//   id_ready                   : decode accepts the held instruction
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               id_ready
);

  fetch_state_e      state_q, state_d;
  logic              discard_q, discard_d;
  logic              pc_inc;
  logic              out_load;
  logic              out_clr;
  logic [ADDR_W-1:0] pc;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (redirect_valid),
    .load_pc(redirect_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    pc_inc    = 1'b0;
    out_load  = 1'b0;
    out_clr   = redirect_valid;
    case (state_q)
      FETCH: begin
        if (imem_gnt) begin
          state_d   = WAIT;
          // The granted request targets the old pc; its response is stale.
          discard_d = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          discard_d = 1'b0;
          if (discard_q || redirect_valid) begin
            state_d = FETCH;
          end else begin
            state_d  = HOLD;
            out_load = 1'b1;
            pc_inc   = 1'b1;
          end
        end else if (redirect_valid) begin
          discard_d = 1'b1;
        end
      end
      HOLD: begin
        // A redirect flushes the held instruction even if decode is ready.
        if (redirect_valid || id_ready) begin
          state_d = FETCH;
          out_clr = 1'b1;
        end
      end
      default: begin
        state_d   = FETCH;
        discard_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
    end else if (out_load) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end else if (out_clr) begin
      if_valid <= 1'b0;
    end
  end

  // Held low during reset so no request leaks out before pc is valid.
  assign imem_req  = rst_n && (state_q == FETCH);
  assign imem_addr = pc;

endmodule
